// File: rtl/tank_level_emulator_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared constants and encodings for the tank plant model. The controller
// bench imports the same package so both sides agree on thresholds, rates
// and on the flow_state / fault_sel encodings.
// -----------------------------------------------------------------------------
package tank_pkg;

    // Direction of the net volume change, as reported on flow_state.
    typedef enum logic [1:0] {
        FLOW_STABLE   = 2'b00,
        FLOW_FILLING  = 2'b01,
        FLOW_DRAINING = 2'b10
    } flow_t;

    // Stuck-sensor fault selection.
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_L_STUCK0 = 2'b01,
        FAULT_M_STUCK1 = 2'b10,
        FAULT_H_STUCK1 = 2'b11
    } fault_t;

    // Default plant parameters.
    localparam int DEF_TICK_DIV   = 50000000;
    localparam int DEF_VOL_W      = 7;
    localparam int DEF_CAP        = 100;
    localparam int DEF_INIT_LEVEL = 0;
    localparam int DEF_L_TH       = 10;
    localparam int DEF_M_TH       = 50;
    localparam int DEF_H_TH       = 90;
    localparam int DEF_HYST       = 2;
    localparam int DEF_FILL_RATE  = 4;
    localparam int DEF_DRIP_RATE  = 1;
    localparam int DEF_SPRAY_RATE = 3;

    // Map the sign of a volume delta onto the flow encoding.
    function automatic flow_t flowFromSign(input logic isPositive, input logic isNegative);
        flow_t f;
        if (isPositive) begin
            f = FLOW_FILLING;
        end else if (isNegative) begin
            f = FLOW_DRAINING;
        end else begin
            f = FLOW_STABLE;
        end
        return f;
    endfunction

endpackage

// File: rtl/tank_level_emulator_level_switch.sv
// -----------------------------------------------------------------------------
// level_switch
// Hysteretic level comparator. The switch closes when level >= TH and opens
// when level < TH-HYST; in between it keeps its previous state. The output is
// registered, so it lags the level input by one clock.
//   clk   : system clock
//   reset : synchronous active-high reset (switch open)
//   level : current volume
//   sw    : registered switch state
// -----------------------------------------------------------------------------
module level_switch #(
    parameter int TH    = 10,
    parameter int HYST  = 2,
    parameter int VOL_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VOL_W-1:0] level,
    output logic             sw
);

    localparam int FALL_TH = TH - HYST;
    // A non-positive falling threshold means the switch can never reopen.
    localparam logic [VOL_W-1:0] RISE_V = VOL_W'(TH);
    localparam logic [VOL_W-1:0] FALL_V = VOL_W'((FALL_TH > 0) ? FALL_TH : 0);

    logic sw_r;

    // Comparator state with hold band between FALL_V and RISE_V.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_r <= 1'b0;
        end else if (level >= RISE_V) begin
            sw_r <= 1'b1;
        end else if (level < FALL_V) begin
            sw_r <= 1'b0;
        end
    end

    assign sw = sw_r;

endmodule

// File: rtl/tank_level_emulator.sv
// -----------------------------------------------------------------------------
// tank_level_emulator
// Plant model of a water tank for closing the irrigation controller loop on
// boards without a physical tank. Every TICK_DIV clocks the volume is
// integrated from the valve commands; three hysteretic switches derive the
// thermometer-coded H/M/L sensors, with an optional stuck-sensor overlay.
//   clk, reset       : clock, synchronous active-high reset
//   Ve, Vs, Bs       : inlet / drip / sprinkler commands (sampled on tick)
//   load, load_val   : one-cycle preset of the volume (clamped to CAP)
//   fault_sel        : sensor fault injection (see tank_pkg::fault_t)
//   clr_flags        : clears the sticky overflow / dry_run flags
//   H, M, L          : level sensors
//   level            : current volume
//   flow_state       : last step direction (tank_pkg::flow_t)
//   overflow, dry_run: sticky flags
//   tick             : one-cycle step strobe
// -----------------------------------------------------------------------------
module tank_level_emulator
    import tank_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int VOL_W      = DEF_VOL_W,
    parameter int CAP        = DEF_CAP,
    parameter int INIT_LEVEL = DEF_INIT_LEVEL,
    parameter int L_TH       = DEF_L_TH,
    parameter int M_TH       = DEF_M_TH,
    parameter int H_TH       = DEF_H_TH,
    parameter int HYST       = DEF_HYST,
    parameter int FILL_RATE  = DEF_FILL_RATE,
    parameter int DRIP_RATE  = DEF_DRIP_RATE,
    parameter int SPRAY_RATE = DEF_SPRAY_RATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Ve,
    input  logic             Vs,
    input  logic             Bs,
    input  logic             load,
    input  logic [VOL_W-1:0] load_val,
    input  logic [1:0]       fault_sel,
    input  logic             clr_flags,
    output logic             H,
    output logic             M,
    output logic             L,
    output logic [VOL_W-1:0] level,
    output logic [1:0]       flow_state,
    output logic             overflow,
    output logic             dry_run,
    output logic             tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW    = VOL_W + 2;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [VOL_W-1:0]        CAP_V    = VOL_W'(CAP);
    localparam logic [VOL_W-1:0]        INIT_V   = VOL_W'(INIT_LEVEL);
    localparam logic signed [DW-1:0]    ZERO_D   = {DW{1'b0}};
    localparam logic signed [DW-1:0]    CAP_D    = DW'(CAP);
    localparam logic signed [DW-1:0]    FILL_D   = DW'(FILL_RATE);
    localparam logic signed [DW-1:0]    DRIP_D   = DW'(DRIP_RATE);
    localparam logic signed [DW-1:0]    SPRAY_D  = DW'(SPRAY_RATE);

    logic [CNT_W-1:0]     preCnt_r;
    logic [CNT_W-1:0]     preCntNext_s;
    logic                 tick_r;
    logic [VOL_W-1:0]     level_r;
    flow_t                flow_r;
    flow_t                flowNext_s;
    logic                 overflow_r;
    logic                 dryRun_r;
    logic signed [DW-1:0] delta_s;
    logic signed [DW-1:0] sum_s;
    logic [VOL_W-1:0]     satNext_s;
    logic                 overflowHit_s;
    logic                 dryHit_s;
    logic                 stepEn_s;
    logic [VOL_W-1:0]     loadClamp_s;
    logic                 rawH_s;
    logic                 rawM_s;
    logic                 rawL_s;
    logic                 ovlH_s;
    logic                 ovlM_s;
    logic                 ovlL_s;
    logic                 H_r;
    logic                 M_r;
    logic                 L_r;

    // Prescaler next-count with wrap at TICK_DIV-1.
    always_comb begin
        preCntNext_s = preCnt_r + CNT_W'(1);
        if (preCnt_r == CNT_LAST) begin
            preCntNext_s = {CNT_W{1'b0}};
        end else begin
            preCntNext_s = preCnt_r + CNT_W'(1);
        end
    end

    // Prescaler; tick is registered so it is high exactly while the count
    // sits at TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            preCnt_r <= {CNT_W{1'b0}};
            tick_r   <= 1'b0;
        end else begin
            preCnt_r <= preCntNext_s;
            tick_r   <= (preCntNext_s == CNT_LAST);
        end
    end

    // Step arithmetic: signed delta, saturated next volume and flag events.
    always_comb begin
        delta_s  = (Ve ? FILL_D : ZERO_D) - (Vs ? DRIP_D : ZERO_D) - (Bs ? SPRAY_D : ZERO_D);
        sum_s    = $signed({2'b00, level_r}) + delta_s;
        stepEn_s = tick_r & ~load;
        dryHit_s = (Vs | Bs) & (level_r == {VOL_W{1'b0}});
        flowNext_s = flowFromSign(delta_s > ZERO_D, delta_s < ZERO_D);
        if (sum_s < ZERO_D) begin
            satNext_s     = {VOL_W{1'b0}};
            overflowHit_s = 1'b0;
        end else if (sum_s > CAP_D) begin
            satNext_s     = CAP_V;
            overflowHit_s = 1'b1;
        end else begin
            satNext_s     = sum_s[VOL_W-1:0];
            overflowHit_s = 1'b0;
        end
        if (load_val > CAP_V) begin
            loadClamp_s = CAP_V;
        end else begin
            loadClamp_s = load_val;
        end
    end

    // Volume integrator and flow direction; a preset wins over a step.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r <= INIT_V;
            flow_r  <= FLOW_STABLE;
        end else if (load) begin
            level_r <= loadClamp_s;
        end else if (tick_r) begin
            level_r <= satNext_s;
            flow_r  <= flowNext_s;
        end
    end

    // Sticky flags; a setting event beats a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r <= 1'b0;
            dryRun_r   <= 1'b0;
        end else begin
            if (stepEn_s && overflowHit_s) begin
                overflow_r <= 1'b1;
            end else if (clr_flags) begin
                overflow_r <= 1'b0;
            end
            if (stepEn_s && dryHit_s) begin
                dryRun_r <= 1'b1;
            end else if (clr_flags) begin
                dryRun_r <= 1'b0;
            end
        end
    end

    level_switch #(.TH(L_TH), .HYST(HYST), .VOL_W(VOL_W)) uSwL (
        .clk   (clk),
        .reset (reset),
        .level (level_r),
        .sw    (rawL_s)
    );

    level_switch #(.TH(M_TH), .HYST(HYST), .VOL_W(VOL_W)) uSwM (
        .clk   (clk),
        .reset (reset),
        .level (level_r),
        .sw    (rawM_s)
    );

    level_switch #(.TH(H_TH), .HYST(HYST), .VOL_W(VOL_W)) uSwH (
        .clk   (clk),
        .reset (reset),
        .level (level_r),
        .sw    (rawH_s)
    );

    // Stuck-sensor overlay on the raw comparator outputs.
    always_comb begin
        ovlH_s = rawH_s;
        ovlM_s = rawM_s;
        ovlL_s = rawL_s;
        case (fault_t'(fault_sel))
            FAULT_NONE:     begin ovlH_s = rawH_s; ovlM_s = rawM_s; ovlL_s = rawL_s; end
            FAULT_L_STUCK0: begin ovlL_s = 1'b0; end
            FAULT_M_STUCK1: begin ovlM_s = 1'b1; end
            FAULT_H_STUCK1: begin ovlH_s = 1'b1; end
            default:        begin ovlH_s = rawH_s; ovlM_s = rawM_s; ovlL_s = rawL_s; end
        endcase
    end

    // Sensor output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            H_r <= 1'b0;
            M_r <= 1'b0;
            L_r <= 1'b0;
        end else begin
            H_r <= ovlH_s;
            M_r <= ovlM_s;
            L_r <= ovlL_s;
        end
    end

    assign H          = H_r;
    assign M          = M_r;
    assign L          = L_r;
    assign level      = level_r;
    assign flow_state = flow_r;
    assign overflow   = overflow_r;
    assign dry_run    = dryRun_r;
    assign tick       = tick_r;

endmodule

// File: tb/tb_tank_level_emulator.sv
// -----------------------------------------------------------------------------
// tb_tank_level_emulator
// Directed bench for tank_level_emulator with TICK_DIV=4. Inputs change and
// outputs are sampled on the falling clock edge. Sensor outputs lag the
// volume by two clocks (comparator register plus overlay register).
// -----------------------------------------------------------------------------
module tb_tank_level_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Ve = 1'b0;
    logic       Vs = 1'b0;
    logic       Bs = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_val = 7'd0;
    logic [1:0] fault_sel = 2'b00;
    logic       clr_flags = 1'b0;
    logic       H;
    logic       M;
    logic       L;
    logic [6:0] level;
    logic [1:0] flow_state;
    logic       overflow;
    logic       dry_run;
    logic       tick;

    int checks = 0;
    int failures = 0;

    tank_level_emulator #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Ve         (Ve),
        .Vs         (Vs),
        .Bs         (Bs),
        .load       (load),
        .load_val   (load_val),
        .fault_sel  (fault_sel),
        .clr_flags  (clr_flags),
        .H          (H),
        .M          (M),
        .L          (L),
        .level      (level),
        .flow_state (flow_state),
        .overflow   (overflow),
        .dry_run    (dry_run),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for a tick, then step past the edge that applies it.
    task automatic waitTick();
        int k;
        k = 0;
        while (tick !== 1'b1 && k < 16) begin
            @(negedge clk);
            k++;
        end
        check("tick_seen", {31'd0, tick}, 32'd1);
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [6:0] v);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        cyc(2);
        check("rst_level", level, 0);
        check("rst_flow", flow_state, 0);
        check("rst_HML", {H, M, L}, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dry", dry_run, 0);
        check("rst_tick", tick, 0);
        reset = 1'b0;

        // First tick after reset
        cyc(1);
        check("pre_tick1", tick, 0);
        cyc(1);
        check("pre_tick2", tick, 0);
        cyc(1);
        check("pre_tick3", tick, 1);

        // Fill from empty
        Ve = 1'b1;
        waitTick();
        check("fill_4", level, 4);
        check("fill_flow", flow_state, 1);
        waitTick();
        check("fill_8", level, 8);
        waitTick();
        check("fill_12", level, 12);
        check("fill_L_pre", L, 0);
        cyc(1);
        check("fill_L_lag", L, 0);
        cyc(1);
        check("fill_HML", {H, M, L}, 3'b001);
        Ve = 1'b0;

        // Overflow and clamp
        doLoad(7'd98);
        check("load_98", level, 98);
        Ve = 1'b1;
        waitTick();
        Ve = 1'b0;
        check("ovf_level", level, 100);
        check("ovf_flag", overflow, 1);
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        check("ovf_clear", overflow, 0);
        doLoad(7'd120);
        check("load_clamp", level, 100);

        // Hysteresis on M
        doLoad(7'd52);
        cyc(3);
        check("hys_M52", M, 1);
        Bs = 1'b1;
        waitTick();
        Bs = 1'b0;
        check("hys_lvl49", level, 49);
        check("hys_flow_drain", flow_state, 2);
        cyc(2);
        check("hys_M49", M, 1);
        Vs = 1'b1;
        waitTick();
        waitTick();
        Vs = 1'b0;
        check("hys_lvl47", level, 47);
        cyc(2);
        check("hys_M47", M, 0);
        doLoad(7'd49);
        cyc(3);
        check("hys_M49_up", M, 0);
        doLoad(7'd50);
        cyc(3);
        check("hys_M50_up", M, 1);

        // Combined flow
        Ve = 1'b1;
        waitTick();
        check("comb_54", level, 54);
        check("comb_flow_fill", flow_state, 1);
        Vs = 1'b1;
        Bs = 1'b1;
        waitTick();
        check("comb_hold", level, 54);
        check("comb_flow_stable", flow_state, 0);
        Ve = 1'b0;
        Vs = 1'b0;
        Bs = 1'b0;

        // Dry run
        doLoad(7'd3);
        Vs = 1'b1;
        Bs = 1'b1;
        waitTick();
        check("dry_lvl0", level, 0);
        check("dry_first", dry_run, 0);
        check("dry_flow", flow_state, 2);
        waitTick();
        check("dry_second", dry_run, 1);
        check("dry_ovf", overflow, 0);
        Vs = 1'b0;
        Bs = 1'b0;
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        check("dry_clear", dry_run, 0);

        // Fault overlay
        doLoad(7'd60);
        cyc(3);
        check("flt_none60", {H, M, L}, 3'b011);
        fault_sel = 2'b01;
        cyc(1);
        check("flt_L0", {H, M, L}, 3'b010);
        fault_sel = 2'b11;
        cyc(1);
        check("flt_H1_60", {H, M, L}, 3'b111);
        doLoad(7'd5);
        cyc(3);
        check("flt_H1_5", {H, M, L}, 3'b100);
        fault_sel = 2'b10;
        cyc(1);
        check("flt_M1_5", {H, M, L}, 3'b010);
        check("flt_level", level, 5);
        fault_sel = 2'b00;
        cyc(1);
        check("flt_clear", {H, M, L}, 3'b000);

        // Reset mid-step
        Ve = 1'b1;
        waitTick();
        check("mid_lvl9", level, 9);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        check("mid_rst_level", level, 0);
        check("mid_rst_flow", flow_state, 0);
        check("mid_rst_tick", tick, 0);
        check("mid_rst_HML", {H, M, L}, 0);
        reset = 1'b0;
        cyc(1);
        check("mid_tick1", tick, 0);
        cyc(1);
        check("mid_tick2", tick, 0);
        check("mid_hold0", level, 0);
        cyc(1);
        check("mid_tick3", tick, 1);
        cyc(1);
        check("mid_step4", level, 4);
        Ve = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
